alarm_monitor_n: RTL
====================

Name: alarm_monitor_n

Overview:
- Parametrised successor to the A13 alarm logic: N independent watchdog/stuck-detect channels, a sticky restart latch, a GOJAM request pulser and a hysteretic warning filter.
- Replaces fixed-function alarms (night watchman, TC trap, rupt lock, warning filter) with one configurable, clocked block.
- Sits between the scaler (TICK strobe) and the restart/GOJAM logic. It feeds RESTRT and AGCWAR to the DSKY/PSM interface.

Parameters:
- N_CH, 4, number of alarm channels (1..16).
- CNT_W, 4, per-channel timeout counter width.
- LIMIT, 10, timeout in TICKs. Legal range 1..2**CNT_W-1. Elaboration error if out of range.
- CH_MODE, 4'b0000, per-channel mode bit. 0 = WATCHDOG (alarm if no kick), 1 = STUCK (alarm if input held).
- N_WARN, 3, number of warning inputs.
- FILT_W, 6, warning filter counter width.
- FILT_HI, 48, count at or above which AGCWAR sets.
- FILT_LO, 16, count at or below which AGCWAR clears. Must be < FILT_HI.
- JAM_LEN, 4, GOJAM_REQ pulse length in CLK cycles (>=1).

Ports:
- CLK  in  1  system clock.
- RST_  in  1  synchronous reset, active-low.
- TICK  in  1  one-cycle scaler strobe, the timebase for all counters.
- CH_EN  in  N_CH  per-channel enable.
- CH_ACT  in  N_CH  WATCHDOG: kick pulse. STUCK: monitored level.
- ERRST  in  1  error reset; clears alarms and RESTRT.
- WARN_IN  in  N_WARN  raw warning conditions (VFAIL, SCAFAL, etc.).
- CH_ALM  out  N_CH  latched per-channel alarms.
- RESTRT  out  1  sticky restart indicator.
- GOJAM_REQ  out  1  restart request pulse.
- AGCWAR  out  1  filtered warning.
- FILT_CNT  out  FILT_W  filter count, for debug and test.

Behaviour:
- Reset: RST_ low at a CLK edge clears all counters and all outputs. It takes priority over every other input. Reset mid-pulse truncates GOJAM_REQ.
- Channel counter, WATCHDOG mode:
  - CH_ACT high: counter goes to 0. This holds even if TICK is high in the same cycle; kick wins.
  - Otherwise: counter increments on TICK.
- Channel counter, STUCK mode:
  - CH_ACT low: counter goes to 0.
  - CH_ACT high: counter increments on TICK.
- Counter saturates at LIMIT and never wraps.
- CH_EN low: counter is held at 0 and no new alarm is raised. An existing CH_ALM bit is retained.
- Alarm set: when a TICK increments the counter from LIMIT-1 to LIMIT, CH_ALM[i] sets on that same edge. It is visible the cycle after the TICK.
  - While saturated, no re-set event is generated unless the counter first clears.
- ERRST (level) clears all CH_ALM and RESTRT. If a set event and ERRST occur in the same cycle, set wins: the bit stays 1.
- RESTRT sets on the same edge as any CH_ALM bit going 0→1. It stays set until ERRST.
- GOJAM_REQ:
  - Any CH_ALM 0→1 transition loads a down-counter with JAM_LEN.
  - GOJAM_REQ is high while the down-counter is nonzero, giving exactly JAM_LEN cycles starting the cycle after the set edge.
  - A new alarm during a pulse reloads the counter, extending the pulse.
  - ERRST does not truncate the pulse.
- Warning filter, evaluated on TICK only:
  - If any WARN_IN is high, FILT_CNT increments, saturating at 2**FILT_W-1.
  - Otherwise FILT_CNT decrements, saturating at 0.
- AGCWAR uses registered hysteresis on the updated count:
  - Sets on the edge where the new count >= FILT_HI.
  - Clears on the edge where the new count <= FILT_LO.
  - Otherwise holds its value.
- Simultaneous events across channels are independent. Multiple alarms on one edge produce a single GOJAM_REQ load.

Decomposition:
- Package alarm_monitor_pkg:
  - ch_mode_e enum (WATCHDOG=0, STUCK=1).
  - Parameter-check functions.
  - Default constants for LIMIT, FILT_HI, FILT_LO and JAM_LEN.
- Sub-module alarm_watchdog_ch:
  - One channel: counter, mode mux, set-event output, CH_ALM flop with ERRST.
  - Instantiated N_CH times by a generate loop.
- The filter, RESTRT and GOJAM logic stay in the top level.

Test Plan:
- Reset: hold RST_ low 3 cycles with all inputs toggling → every output is 0, FILT_CNT=0.
- Watchdog timeout:
  - Ch0 in WATCHDOG with CH_EN=1, no kick, 10 TICKs → CH_ALM[0]=1 and RESTRT=1 the cycle after the 10th TICK, then GOJAM_REQ high for exactly 4 cycles.
  - Repeat with a kick on the 9th TICK cycle → no alarm.
- Stuck detect (CH_MODE[1]=1):
  - CH_ACT[1] held high for 10 TICKs → CH_ALM[1]=1.
  - Dropping CH_ACT[1] after 9 TICKs → counter returns to 0 and no alarm is raised.
- ERRST race:
  - Assert ERRST on the same edge as ch2's 10th TICK → CH_ALM[2]=1 and RESTRT=1 after the edge.
  - Next cycle with ERRST still high → both cleared.
- GOJAM retrigger: alarm ch0, then alarm ch3 two cycles later → GOJAM_REQ high for 6 consecutive cycles.
- Filter hysteresis:
  - WARN_IN[0] high for 48 TICKs → AGCWAR=1 at FILT_CNT=48.
  - Continue to 70 TICKs → saturation at 63.
  - Drop WARN_IN; AGCWAR stays 1 down through FILT_CNT=17 and clears when FILT_CNT reaches 16.

Source files
------------

// File: rtl/alarm_monitor_pkg.sv
// Shared types, defaults and elaboration-time parameter checks for the
// alarm monitor family.
package alarm_monitor_pkg;

  typedef enum logic {
    WATCHDOG = 1'b0,
    STUCK    = 1'b1
  } ch_mode_e;

  localparam int DEF_LIMIT   = 10;
  localparam int DEF_FILT_HI = 48;
  localparam int DEF_FILT_LO = 16;
  localparam int DEF_JAM_LEN = 4;

  function automatic bit n_ch_ok(input int n_ch);
    return (n_ch >= 1) && (n_ch <= 16);
  endfunction

  function automatic bit limit_ok(input int limit, input int cnt_w);
    return (limit >= 1) && (limit <= ((1 << cnt_w) - 1));
  endfunction

  function automatic bit filt_ok(input int hi, input int lo, input int filt_w);
    return (lo >= 0) && (lo < hi) && (hi <= ((1 << filt_w) - 1));
  endfunction

  function automatic bit jam_ok(input int jam_len);
    return jam_len >= 1;
  endfunction

endpackage

// File: rtl/alarm_monitor_n_if.sv
// Bundle of strobes, channel/warning inputs and alarm outputs around the
// alarm monitor; the monitor itself is the slave side.
interface alarm_monitor_n_if #(
  parameter int N_CH   = 4,
  parameter int N_WARN = 3,
  parameter int FILT_W = 6
);
  logic              TICK;
  logic [N_CH-1:0]   CH_EN;
  logic [N_CH-1:0]   CH_ACT;
  logic              ERRST;
  logic [N_WARN-1:0] WARN_IN;
  logic [N_CH-1:0]   CH_ALM;
  logic              RESTRT;
  logic              GOJAM_REQ;
  logic              AGCWAR;
  logic [FILT_W-1:0] FILT_CNT;

  modport master (
    output TICK, CH_EN, CH_ACT, ERRST, WARN_IN,
    input  CH_ALM, RESTRT, GOJAM_REQ, AGCWAR, FILT_CNT
  );

  modport slave (
    input  TICK, CH_EN, CH_ACT, ERRST, WARN_IN,
    output CH_ALM, RESTRT, GOJAM_REQ, AGCWAR, FILT_CNT
  );
endinterface

// File: rtl/alarm_watchdog_ch.sv
// One alarm channel: saturating timeout counter, mode-dependent clear,
// latched alarm bit and a 0->1 rise flag for the restart logic.
module alarm_watchdog_ch
  import alarm_monitor_pkg::*;
#(
  parameter int       CNT_W = 4,
  parameter int       LIMIT = DEF_LIMIT,
  parameter ch_mode_e MODE  = WATCHDOG
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic en,
  input  logic act,
  input  logic errst,
  output logic alm,
  output logic rise
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alm_q, alm_d;
  logic             clr_s, set_s;

  // Counter next-state and alarm latch; a set event beats ERRST.
  always_comb begin
    clr_s = (MODE == STUCK) ? ~act : act;
    set_s = en & ~clr_s & tick & (cnt_q == LIM_M1);
    if (!en || clr_s) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (set_s) begin
      alm_d = 1'b1;
    end else if (errst) begin
      alm_d = 1'b0;
    end else begin
      alm_d = alm_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      alm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      alm_q <= alm_d;
    end
  end

  assign alm  = alm_q;
  assign rise = set_s & ~alm_q;

endmodule

// File: rtl/alarm_monitor_n.sv
// Parametrised alarm monitor: N watchdog/stuck channels, sticky restart,
// GOJAM request pulser and hysteretic warning filter.
module alarm_monitor_n
  import alarm_monitor_pkg::*;
#(
  parameter int              N_CH    = 4,
  parameter int              CNT_W   = 4,
  parameter int              LIMIT   = DEF_LIMIT,
  parameter logic [N_CH-1:0] CH_MODE = '0,
  parameter int              N_WARN  = 3,
  parameter int              FILT_W  = 6,
  parameter int              FILT_HI = DEF_FILT_HI,
  parameter int              FILT_LO = DEF_FILT_LO,
  parameter int              JAM_LEN = DEF_JAM_LEN
) (
  input logic              CLK,
  input logic              RST_,
  alarm_monitor_n_if.slave bus
);

  localparam int               JAM_W    = $clog2(JAM_LEN + 1);
  localparam logic [JAM_W-1:0] JAM_LOAD = JAM_W'(JAM_LEN);
  localparam logic [FILT_W-1:0] FMAX    = '1;
  localparam logic [FILT_W-1:0] FHI     = FILT_W'(FILT_HI);
  localparam logic [FILT_W-1:0] FLO     = FILT_W'(FILT_LO);

  if (!n_ch_ok(N_CH))                     begin : g_bad_nch   $error("N_CH out of range");  end
  if (!limit_ok(LIMIT, CNT_W))            begin : g_bad_limit $error("LIMIT out of range"); end
  if (!filt_ok(FILT_HI, FILT_LO, FILT_W)) begin : g_bad_filt  $error("bad filter bounds");  end
  if (!jam_ok(JAM_LEN))                   begin : g_bad_jam   $error("JAM_LEN must be >= 1"); end
  if (N_WARN < 1)                         begin : g_bad_warn  $error("N_WARN must be >= 1"); end

  logic [N_CH-1:0]   ch_alm_s, ch_rise_s;
  logic              any_rise_s, any_warn_s;
  logic              restrt_q, restrt_d;
  logic [JAM_W-1:0]  jam_q, jam_d;
  logic              gojam_q, gojam_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic              war_q, war_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    alarm_watchdog_ch #(
      .CNT_W (CNT_W),
      .LIMIT (LIMIT),
      .MODE  (ch_mode_e'(CH_MODE[i]))
    ) u_ch (
      .clk   (CLK),
      .rst_n (RST_),
      .tick  (bus.TICK),
      .en    (bus.CH_EN[i]),
      .act   (bus.CH_ACT[i]),
      .errst (bus.ERRST),
      .alm   (ch_alm_s[i]),
      .rise  (ch_rise_s[i])
    );
  end

  // Restart latch, GOJAM down-counter and warning filter next-state.
  always_comb begin
    any_rise_s = |ch_rise_s;
    any_warn_s = |bus.WARN_IN;

    if (any_rise_s) begin
      restrt_d = 1'b1;
    end else if (bus.ERRST) begin
      restrt_d = 1'b0;
    end else begin
      restrt_d = restrt_q;
    end

    if (any_rise_s) begin
      jam_d = JAM_LOAD;
    end else if (jam_q != '0) begin
      jam_d = jam_q - JAM_W'(1);
    end else begin
      jam_d = jam_q;
    end
    gojam_d = (jam_d != '0);

    if (!bus.TICK) begin
      filt_d = filt_q;
    end else if (any_warn_s) begin
      filt_d = (filt_q == FMAX) ? filt_q : filt_q + FILT_W'(1);
    end else begin
      filt_d = (filt_q == '0) ? filt_q : filt_q - FILT_W'(1);
    end

    // Hysteresis acts on the freshly updated count.
    if (bus.TICK && (filt_d >= FHI)) begin
      war_d = 1'b1;
    end else if (bus.TICK && (filt_d <= FLO)) begin
      war_d = 1'b0;
    end else begin
      war_d = war_q;
    end
  end

  // Top-level state registers.
  always_ff @(posedge CLK) begin
    if (!RST_) begin
      restrt_q <= 1'b0;
      jam_q    <= '0;
      gojam_q  <= 1'b0;
      filt_q   <= '0;
      war_q    <= 1'b0;
    end else begin
      restrt_q <= restrt_d;
      jam_q    <= jam_d;
      gojam_q  <= gojam_d;
      filt_q   <= filt_d;
      war_q    <= war_d;
    end
  end

  assign bus.CH_ALM    = ch_alm_s;
  assign bus.RESTRT    = restrt_q;
  assign bus.GOJAM_REQ = gojam_q;
  assign bus.AGCWAR    = war_q;
  assign bus.FILT_CNT  = filt_q;

endmodule
